layer_scheduler: RTL and testbench
==================================

# layer_scheduler

Sequences one shared neuron MAC datapath (weight/input memories, multiplier, saturating accumulator, bias adder, ReLU) across all neurons of a fully-connected layer. It issues memory read addresses and the per-stage enables, loads each neuron's bias, and returns one activation per neuron on a valid/ready output stream. It sits between the layer-level control (start/done) and the MAC datapath, replacing per-neuron free-running control.

## Interface
- NUM_NEURONS, 30, neurons time-multiplexed onto the datapath
- NUM_INPUTS, 784, inputs (and weights) per neuron
- DATA_WIDTH, 16, activation/weight width
- W_AW, $clog2(NUM_NEURONS*NUM_INPUTS), weight address width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin layer; sampled only in IDLE
- abort  in  1  cancel layer; return to IDLE next cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last neuron's output handshake
- w_rd  out  1  weight memory read enable
- w_addr  out  W_AW  weight address = neuron*NUM_INPUTS + i
- in_rd  out  1  input memory read enable
- in_addr  out  $clog2(NUM_INPUTS)  input address i
- bias_ld  out  1  load bias register
- bias_idx  out  $clog2(NUM_NEURONS)  current neuron index
- acc_clr  out  1  synchronous clear of accumulator
- mul_en, acc_en, bias_add_en, act_en  out  1 each  datapath stage enables
- act_in  in  DATA_WIDTH  ReLU output
- out_valid  out  1  activation available
- out_ready  in  1  consumer accepts
- out_data  out  DATA_WIDTH  registered activation
- out_idx  out  $clog2(NUM_NEURONS)  neuron index of out_data

## Operation
- States: IDLE, CLEAR, MAC, DRAIN, BIAS, ACT, LATCH, EMIT.
- IDLE: all outputs 0. start=1 -> CLEAR, neuron n=0, weight base=0.
- CLEAR (1 cycle): acc_clr=1, bias_ld=1, bias_idx=n. -> MAC, i=0.
- MAC (NUM_INPUTS cycles): w_rd=in_rd=1, w_addr=base+i, in_addr=i; i increments; at i=NUM_INPUTS-1 -> DRAIN.
- mul_en = w_rd delayed 1 cycle; acc_en = w_rd delayed 2 cycles (memory read and multiplier register latencies). Delay line runs in every state, cleared by rst/abort.
- DRAIN (2 cycles): no reads; flushes last mul_en/acc_en. -> BIAS.
- BIAS (1): bias_add_en=1. ACT (1): act_en=1. LATCH (1): out_data<=act_in, out_idx<=n. -> EMIT.
- EMIT: out_valid=1, out_data/out_idx held stable until out_valid&&out_ready. On handshake: if n=NUM_NEURONS-1 -> IDLE with done=1 that cycle (registered pulse); else n<=n+1, base<=base+NUM_INPUTS (adder, no multiplier), -> CLEAR.
- start while busy ignored. abort has priority over all transitions: next state IDLE, counters/delay line cleared, out_valid drops, no done.
- Simultaneous abort and EMIT handshake: handshake counts as taken by consumer, but abort wins; no done.
- i, n never exceed NUM_INPUTS-1 / NUM_NEURONS-1; no wrap beyond layer.

## Timing
- Reset values: every output 0; state IDLE; n=i=base=0.
- start to first w_rd: 2 cycles (CLEAR between).
- Per neuron with out_ready held 1: NUM_INPUTS+7 cycles (CLEAR 1, MAC N, DRAIN 2, BIAS 1, ACT 1, LATCH 1, EMIT 1).
- Layer latency start->done: 1 + NUM_NEURONS*(NUM_INPUTS+7) cycles with out_ready=1; each EMIT stall adds one cycle.
- acc_en last asserted in second DRAIN cycle; bias_add_en strictly after.
- out_valid never deasserts without handshake except abort/rst.

## Structure
- Shared package nn_pkg: state enum, enable-delay depth constants (MEM_LAT=1, MUL_LAT=1), address-width functions.
- One sub-module: en_delay_line (parameterised depth shift register with sync clear) generating mul_en/acc_en from w_rd.

## Test plan
- NUM_NEURONS=3, NUM_INPUTS=4, out_ready=1, start pulse -> w_addr sequence 0..3,4..7,8..11; out_idx 0,1,2; done at cycle 1+3*11=34 after start.
- Weights/inputs all 1, biases 0/1/2 (Q format), known ReLU -> out_data equals 4, 5, 6 scaled; negative bias neuron yields 0.
- out_ready=0 for 5 cycles in first EMIT -> out_valid, out_data, out_idx stable for 6 cycles; done delayed by 5.
- abort in MAC of neuron 1 -> IDLE next cycle, busy=0, no done, no further out_valid; new start restarts at w_addr 0.
- start asserted while busy -> ignored, sequence unchanged; rst asserted mid-EMIT -> all outputs 0 asynchronously.
- Check mul_en/acc_en lag w_rd by exactly 1/2 cycles and count exactly NUM_INPUTS pulses per neuron.

Source files
------------

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types and constants for the layer scheduler
package nn_pkg;

  localparam int MEM_LAT  = 1;
  localparam int MUL_LAT  = 1;
  localparam int EN_DEPTH = MEM_LAT + MUL_LAT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_MAC,
    ST_DRAIN,
    ST_BIAS,
    ST_ACT,
    ST_LATCH,
    ST_EMIT
  } state_e;

  // Index width for a range of 'depth' entries, never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/en_delay_line.sv
// rtl/en_delay_line.sv - enable shift register with synchronous clear
// taps[k] is en_in delayed by k+1 cycles.
module en_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en_in,
  output logic [DEPTH-1:0] taps
);

  logic [DEPTH-1:0] taps_q, taps_d;

  always_comb begin
    taps_d    = '0;
    taps_d[0] = en_in;
    for (int k = 1; k < DEPTH; k++) begin
      taps_d[k] = taps_q[k-1];
    end
    if (clr) begin
      taps_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps_q <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign taps = taps_q;

endmodule

// File: rtl/layer_scheduler.sv
// rtl/layer_scheduler.sv - sequences one shared MAC datapath across a layer
// Walks neurons one at a time and emits one activation per neuron on a valid/ready stream.
module layer_scheduler
  import nn_pkg::*;
#(
  parameter int NUM_NEURONS = 30,
  parameter int NUM_INPUTS  = 784,
  parameter int DATA_WIDTH  = 16,
  parameter int W_AW        = addr_w(NUM_NEURONS * NUM_INPUTS),
  localparam int IN_AW      = addr_w(NUM_INPUTS),
  localparam int IDX_W      = addr_w(NUM_NEURONS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  w_rd,
  output logic [W_AW-1:0]       w_addr,
  output logic                  in_rd,
  output logic [IN_AW-1:0]      in_addr,
  output logic                  bias_ld,
  output logic [IDX_W-1:0]      bias_idx,
  output logic                  acc_clr,
  output logic                  mul_en,
  output logic                  acc_en,
  output logic                  bias_add_en,
  output logic                  act_en,
  input  logic [DATA_WIDTH-1:0] act_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]      out_idx
);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      n_q, n_d;
  logic [IN_AW-1:0]      i_q, i_d;
  logic [W_AW-1:0]       base_q, base_d;
  logic                  drain_q, drain_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]      out_idx_q, out_idx_d;
  logic [EN_DEPTH-1:0]   en_taps;
  logic                  last_input, last_neuron;

  assign last_input  = (i_q == IN_AW'(NUM_INPUTS - 1));
  assign last_neuron = (n_q == IDX_W'(NUM_NEURONS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_CLEAR;
        ST_CLEAR: state_d = ST_MAC;
        ST_MAC:   if (last_input) state_d = ST_DRAIN;
        ST_DRAIN: if (drain_q) state_d = ST_BIAS;
        ST_BIAS:  state_d = ST_ACT;
        ST_ACT:   state_d = ST_LATCH;
        ST_LATCH: state_d = ST_EMIT;
        ST_EMIT:  if (out_ready) state_d = last_neuron ? ST_IDLE : ST_CLEAR;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Counters, the output register and the done pulse.
  always_comb begin
    n_d        = n_q;
    i_d        = i_q;
    base_d     = base_q;
    drain_d    = 1'b0;
    done_d     = 1'b0;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    if (abort) begin
      n_d        = '0;
      i_d        = '0;
      base_d     = '0;
      out_data_d = '0;
      out_idx_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            n_d    = '0;
            i_d    = '0;
            base_d = '0;
          end
        end
        ST_CLEAR: i_d = '0;
        ST_MAC:   if (!last_input) i_d = i_q + IN_AW'(1);
        ST_DRAIN: drain_d = !drain_q;
        ST_LATCH: begin
          out_data_d = act_in;
          out_idx_d  = n_q;
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (last_neuron) begin
              done_d     = 1'b1;
              n_d        = '0;
              i_d        = '0;
              base_d     = '0;
              out_data_d = '0;
              out_idx_d  = '0;
            end else begin
              n_d    = n_q + IDX_W'(1);
              base_d = base_q + W_AW'(NUM_INPUTS);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q        <= '0;
      i_q        <= '0;
      base_q     <= '0;
      drain_q    <= 1'b0;
      done_q     <= 1'b0;
      out_data_q <= '0;
      out_idx_q  <= '0;
    end else begin
      n_q        <= n_d;
      i_q        <= i_d;
      base_q     <= base_d;
      drain_q    <= drain_d;
      done_q     <= done_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
    end
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    w_rd        = (state_q == ST_MAC);
    in_rd       = (state_q == ST_MAC);
    w_addr      = '0;
    in_addr     = '0;
    bias_ld     = (state_q == ST_CLEAR);
    acc_clr     = (state_q == ST_CLEAR);
    bias_idx    = n_q;
    bias_add_en = (state_q == ST_BIAS);
    act_en      = (state_q == ST_ACT);
    out_valid   = (state_q == ST_EMIT);
    if (state_q == ST_MAC) begin
      w_addr  = base_q + W_AW'(i_q);
      in_addr = i_q;
    end
  end

  // Stage enables follow the read strobe through memory and multiplier latency.
  en_delay_line #(
    .DEPTH (EN_DEPTH)
  ) u_en_delay (
    .clk   (clk),
    .rst   (rst),
    .clr   (abort),
    .en_in (w_rd),
    .taps  (en_taps)
  );

  assign mul_en   = en_taps[MEM_LAT-1];
  assign acc_en   = en_taps[EN_DEPTH-1];
  assign done     = done_q;
  assign out_data = out_data_q;
  assign out_idx  = out_idx_q;

endmodule

// File: tb/tb_layer_scheduler.sv
// tb/tb_layer_scheduler.sv - directed self-checking bench for layer_scheduler
// 3 neurons x 4 inputs; a unit-weight datapath model turns the enables into activations.
module tb_layer_scheduler;

  localparam int NN = 3;
  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic        busy, done, w_rd, in_rd, bias_ld, acc_clr;
  logic        mul_en, acc_en, bias_add_en, act_en, out_valid;
  logic [3:0]  w_addr;
  logic [1:0]  in_addr, bias_idx, out_idx;
  logic [15:0] act_in, out_data;
  logic [36:0] all_outs;

  layer_scheduler #(
    .NUM_NEURONS (NN),
    .NUM_INPUTS  (NI),
    .DATA_WIDTH  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .w_rd        (w_rd),
    .w_addr      (w_addr),
    .in_rd       (in_rd),
    .in_addr     (in_addr),
    .bias_ld     (bias_ld),
    .bias_idx    (bias_idx),
    .acc_clr     (acc_clr),
    .mul_en      (mul_en),
    .acc_en      (acc_en),
    .bias_add_en (bias_add_en),
    .act_en      (act_en),
    .act_in      (act_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_idx     (out_idx)
  );

  always #5 clk = ~clk;

  assign all_outs = {busy, done, w_rd, w_addr, in_rd, in_addr, bias_ld, bias_idx, acc_clr,
                     mul_en, acc_en, bias_add_en, act_en, out_valid, out_data, out_idx};

  // Datapath model: weight*input = 1 per accumulate, bias add, ReLU.
  int          bias_tab [4];
  int          acc_m, bias_m, sum_m;
  logic [15:0] act_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_m  <= 0;
      bias_m <= 0;
      sum_m  <= 0;
      act_m  <= '0;
    end else begin
      if (bias_ld) bias_m <= bias_tab[bias_idx];
      if (acc_clr) acc_m <= 0;
      else if (acc_en) acc_m <= acc_m + 1;
      if (bias_add_en) sum_m <= acc_m + bias_m;
      if (act_en) act_m <= (sum_m < 0) ? 16'd0 : sum_m[15:0];
    end
  end
  assign act_in = act_m;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int addrs[$];
  int em_data[$];
  int em_idx[$];
  int done_cyc, extra_done, first_wrd_cyc, valid_run, stable_err;
  int lag_err, mul_cnt, acc_cnt, acc_bias_err, post_abort_bad;

  // Starts a layer in the current cycle (cycle 0) and observes it cycle by cycle.
  task automatic run_layer(input int stall_n, input int abort_cyc, input int dup_start_cyc,
                           input int max_cyc);
    int cyc, stall_left, acc_since_clr;
    logic prev_wrd1, prev_wrd2, prev_valid, prev_hs, abort_prev;
    logic [15:0] prev_data;
    logic [1:0]  prev_idx;
    addrs.delete(); em_data.delete(); em_idx.delete();
    done_cyc = -1; extra_done = 0; first_wrd_cyc = -1; valid_run = 0; stable_err = 0;
    lag_err = 0; mul_cnt = 0; acc_cnt = 0; acc_bias_err = 0; post_abort_bad = 0;
    cyc = 0; stall_left = stall_n; acc_since_clr = 0;
    prev_wrd1 = 1'b0; prev_wrd2 = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0; abort_prev = 1'b0;
    prev_data = '0; prev_idx = '0;
    start = 1'b1;
    while (cyc < max_cyc) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == dup_start_cyc);
      abort = (cyc == abort_cyc);
      if (mul_en !== prev_wrd1 || acc_en !== prev_wrd2) lag_err++;
      prev_wrd2 = prev_wrd1;
      prev_wrd1 = w_rd;
      if (abort) begin
        prev_wrd1 = 1'b0;
        prev_wrd2 = 1'b0;
      end
      if (w_rd) begin
        addrs.push_back(int'(w_addr));
        if (first_wrd_cyc < 0) first_wrd_cyc = cyc;
      end
      if (mul_en) mul_cnt++;
      if (acc_en) acc_cnt++;
      if (acc_clr) acc_since_clr = 0;
      if (acc_en) acc_since_clr++;
      if (bias_add_en && acc_since_clr != NI) acc_bias_err++;
      if (prev_valid && !prev_hs && !abort_prev) begin
        if (!out_valid || out_data !== prev_data || out_idx !== prev_idx) stable_err++;
      end
      if (out_valid) begin
        if (em_data.size() == 0) valid_run++;
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
        if (out_ready) begin
          em_data.push_back(int'(out_data));
          em_idx.push_back(int'(out_idx));
        end
      end else begin
        out_ready = 1'b1;
      end
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
      prev_data  = out_data;
      prev_idx   = out_idx;
      abort_prev = abort;
      if (done) begin
        if (done_cyc < 0) done_cyc = cyc;
        else extra_done++;
      end
      if (abort_cyc >= 0 && cyc > abort_cyc && (busy || out_valid || done)) post_abort_bad++;
      if (done_cyc >= 0 && cyc > done_cyc) break;
    end
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic check_emits(input string tag, input int d0, input int d1, input int d2);
    int exp_d[3];
    exp_d = '{d0, d1, d2};
    check({tag, "_emit_count"}, 64'(em_data.size()), 64'(3));
    for (int k = 0; k < 3; k++) begin
      if (k < em_data.size()) begin
        check($sformatf("%s_data%0d", tag, k), 64'(em_data[k]), 64'(exp_d[k]));
        check($sformatf("%s_idx%0d", tag, k), 64'(em_idx[k]), 64'(k));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    bias_tab = '{0, 1, 2, 0};
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'(all_outs), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_outputs", 64'(all_outs), 64'(0));

    // Normal layer, with a stray start while busy.
    run_layer(0, -1, 5, 60);
    check("a_done_cycle", 64'(done_cyc), 64'(34));
    check("a_done_width", 64'(extra_done), 64'(0));
    check("a_busy_after_done", 64'(busy), 64'(0));
    check("a_first_wrd_cycle", 64'(first_wrd_cyc), 64'(2));
    check("a_addr_count", 64'(addrs.size()), 64'(12));
    for (int j = 0; j < 12; j++) begin
      if (j < addrs.size()) check($sformatf("a_w_addr%0d", j), 64'(addrs[j]), 64'(j));
    end
    check("a_en_lag", 64'(lag_err), 64'(0));
    check("a_mul_pulses", 64'(mul_cnt), 64'(12));
    check("a_acc_pulses", 64'(acc_cnt), 64'(12));
    check("a_acc_before_bias", 64'(acc_bias_err), 64'(0));
    check("a_stable", 64'(stable_err), 64'(0));
    check_emits("a", 4, 5, 6);

    // Negative bias on neuron 0 and a 5-cycle stall in the first EMIT.
    bias_tab = '{-10, 1, 2, 0};
    run_layer(5, -1, -1, 80);
    check("b_done_cycle", 64'(done_cyc), 64'(39));
    check("b_valid_cycles", 64'(valid_run), 64'(6));
    check("b_stable", 64'(stable_err), 64'(0));
    check("b_en_lag", 64'(lag_err), 64'(0));
    check_emits("b", 0, 5, 6);

    // Abort during MAC of neuron 1, then restart.
    bias_tab = '{0, 1, 2, 0};
    run_layer(0, 14, -1, 24);
    check("c_no_done", 64'(done_cyc), 64'(-1));
    check("c_post_abort", 64'(post_abort_bad), 64'(0));
    check("c_emits_before_abort", 64'(em_data.size()), 64'(1));
    check("c_en_lag", 64'(lag_err), 64'(0));
    run_layer(0, -1, -1, 60);
    check("d_first_addr", 64'(addrs.size() > 0 ? addrs[0] : -1), 64'(0));
    check("d_first_wrd_cycle", 64'(first_wrd_cyc), 64'(2));
    check("d_done_cycle", 64'(done_cyc), 64'(34));
    check_emits("d", 4, 5, 6);

    // Asynchronous reset while an activation is waiting in EMIT.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (!out_valid && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("e_reach_emit", 64'(out_valid), 64'(1));
    check("e_emit_data", 64'(out_data), 64'(4));
    #2;
    rst = 1'b1;
    #1;
    check("e_rst_async_outputs", 64'(all_outs), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("e_idle_after_rst", 64'(all_outs), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
